// File: rtl/seq_ops_pkg.sv
// Shared opcodes and the stateless-op helper for seq_operations_pipe.
// Optional build macro SEQ_OPS_SAT_EN (saturating ops 101/110) lives in seq_ops_alu.
package seq_ops_pkg;

  // Stateless ops are evaluated at this width; OUT_W must be below it.
  localparam int MAX_W = 64;

  localparam logic [2:0] OP_ADD3  = 3'b000;
  localparam logic [2:0] OP_MUL   = 3'b001;
  localparam logic [2:0] OP_MAC   = 3'b010;
  localparam logic [2:0] OP_LOGIC = 3'b011;
  localparam logic [2:0] OP_XOR3  = 3'b100;
  localparam logic [2:0] OP_SUB3  = 3'b101;
  localparam logic [2:0] OP_ACC   = 3'b110;
  localparam logic [2:0] OP_CLR   = 3'b111;

  // Returns {ovf, result}; caller truncates result to its own width.
  function automatic logic [MAX_W:0] stateless_op(
    input logic [2:0]       op,
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic [MAX_W-1:0] c
  );
    logic [MAX_W-1:0] r;
    logic             o;
    r = '0;
    o = 1'b0;
    unique case (1'b1)
      op == OP_ADD3:  r = a + b + c;
      op == OP_MUL:   r = a * b;
      op == OP_MAC:   r = a * b + c;
      op == OP_LOGIC: r = (a & b) | c;
      op == OP_XOR3:  r = a ^ b ^ c;
      op == OP_SUB3: begin
        r = a - b - c;
        o = ({1'b0, b} + {1'b0, c}) > {1'b0, a};
      end
      default: begin
        r = '0;
        o = 1'b0;
      end
    endcase
    return {o, r};
  endfunction

endpackage

// File: rtl/seq_ops_alu.sv
// Combinational S2 datapath: stateless ops, accumulate and clear.
// SEQ_OPS_SAT_EN makes ops 101/110 saturate instead of wrapping.
module seq_ops_alu
  import seq_ops_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OUT_W = 2 * WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [2:0]       op,
  input  logic [OUT_W-1:0] acc,
  output logic [OUT_W-1:0] result,
  output logic             ovf,
  output logic [OUT_W-1:0] acc_next
);

  logic [MAX_W-1:0] a_x;
  logic [MAX_W-1:0] b_x;
  logic [MAX_W-1:0] c_x;
  logic [MAX_W:0]   res_x;
  logic [OUT_W-1:0] a_w;
  logic [OUT_W-1:0] b_w;
  logic [OUT_W-1:0] prod;
  logic [OUT_W:0]   mac_sum;
  logic             unused_hi;

  assign a_x = {{(MAX_W-WIDTH){1'b0}}, a};
  assign b_x = {{(MAX_W-WIDTH){1'b0}}, b};
  assign c_x = {{(MAX_W-WIDTH){1'b0}}, c};
  assign res_x = stateless_op(op, a_x, b_x, c_x);
  assign unused_hi = ^res_x[MAX_W-1:OUT_W];

  // The product always fits in OUT_W since OUT_W >= 2*WIDTH.
  assign a_w = {{(OUT_W-WIDTH){1'b0}}, a};
  assign b_w = {{(OUT_W-WIDTH){1'b0}}, b};
  assign prod = a_w * b_w;
  assign mac_sum = {1'b0, acc} + {1'b0, prod};

  always_comb begin
    result   = res_x[OUT_W-1:0];
    ovf      = res_x[MAX_W];
    acc_next = acc;
    unique case (1'b1)
      op == OP_ACC: begin
        result = mac_sum[OUT_W-1:0];
        ovf    = mac_sum[OUT_W];
`ifdef SEQ_OPS_SAT_EN
        if (mac_sum[OUT_W]) result = '1;
`endif
        acc_next = result;
      end
      op == OP_CLR: begin
        result   = '0;
        ovf      = 1'b0;
        acc_next = '0;
      end
`ifdef SEQ_OPS_SAT_EN
      op == OP_SUB3: begin
        if (res_x[MAX_W]) result = '0;
      end
`endif
      default: begin
        acc_next = acc;
      end
    endcase
  end

endmodule

// File: rtl/seq_operations_pipe.sv
// Two-stage three-operand op pipeline with accumulator and valid/ready flow.
// Build option SEQ_OPS_SAT_EN selects saturating ops (see seq_ops_alu).
module seq_operations_pipe
  import seq_ops_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OUT_W = 2 * WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Seq1,
  input  logic [WIDTH-1:0] Seq2,
  input  logic [WIDTH-1:0] Seq3,
  input  logic [2:0]       Op,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [OUT_W-1:0] Seq_out,
  output logic             Ovf
);

  logic             run;
  logic             advance;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_c;
  logic [2:0]       s1_op;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] alu_res;
  logic [OUT_W-1:0] acc_next;
  logic             alu_ovf;

  // Keeps In_Ready low through reset and for the edge that ends it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) run <= 1'b0;
    else     run <= 1'b1;
  end

  assign advance  = !Out_Valid | Out_Ready;
  assign In_Ready = run & (!s1_valid | advance);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s1_op    <= '0;
    end else if (In_Ready) begin
      s1_valid <= In_Valid;
      if (In_Valid) begin
        s1_a  <= Seq1;
        s1_b  <= Seq2;
        s1_c  <= Seq3;
        s1_op <= Op;
      end
    end
  end

  seq_ops_alu #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_alu (
    .a        (s1_a),
    .b        (s1_b),
    .c        (s1_c),
    .op       (s1_op),
    .acc      (acc),
    .result   (alu_res),
    .ovf      (alu_ovf),
    .acc_next (acc_next)
  );

  // acc_next equals acc for non-accumulator ops, so one guarded load suffices.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Out_Valid <= 1'b0;
      Seq_out   <= '0;
      Ovf       <= 1'b0;
      acc       <= '0;
    end else if (advance) begin
      Out_Valid <= s1_valid;
      if (s1_valid) begin
        Seq_out <= alu_res;
        Ovf     <= alu_ovf;
        acc     <= acc_next;
      end
    end
  end

endmodule
